// File: rtl/oflow_score_board_pkg.sv
// Shared constants, state encoding and result record layout
// for the registration score board.
package oflow_score_board_pkg;

  localparam int NUM_PE  = 8;
  localparam int SCORE_W = 16;
  localparam int ID_W    = 7;
  localparam int SET_LEN = 5;

  localparam logic [SCORE_W-1:0] SCORE_THRESH = 16'h0800;

  localparam int PE_W   = $clog2(NUM_PE);
  localparam int ADDR_W = SET_LEN + PE_W;
  localparam int DATA_W = 1 + ID_W + SCORE_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;

  typedef struct packed {
    logic               found;
    logic [ID_W-1:0]    id;
    logic [SCORE_W-1:0] score;
  } wr_rec_t;

  function automatic wr_rec_t make_rec(
    input logic [SCORE_W-1:0] s,
    input logic [ID_W-1:0]    id
  );
    wr_rec_t r;
    r.found = (s <= SCORE_THRESH);
    r.id    = r.found ? id : '1;
    r.score = s;
    return r;
  endfunction

endpackage

// File: rtl/oflow_score_board_if.sv
// Score-calc side and result-buffer side signals of the
// score board, bundled with producer/consumer modports.
interface oflow_score_board_if;
  import oflow_score_board_pkg::*;

  logic                      start_score_calc;
  logic [SET_LEN-1:0]        counter_of_sets;
  logic [SET_LEN-1:0]        num_of_sets;
  logic                      done_score_calc;
  logic [NUM_PE-1:0]         score_valid;
  logic [NUM_PE*SCORE_W-1:0] score;
  logic [NUM_PE*ID_W-1:0]    score_id;
  logic                      clr_status;

  logic                      ready;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      done_score_board;
  logic                      overrun;

  modport master (
    output start_score_calc,
    output counter_of_sets,
    output num_of_sets,
    output done_score_calc,
    output score_valid,
    output score,
    output score_id,
    output clr_status,
    input  ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  done_score_board,
    input  overrun
  );

  modport slave (
    input  start_score_calc,
    input  counter_of_sets,
    input  num_of_sets,
    input  done_score_calc,
    input  score_valid,
    input  score,
    input  score_id,
    input  clr_status,
    output ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output done_score_board,
    output overrun
  );

endinterface

// File: rtl/oflow_score_board_min_reg.sv
// One PE's running minimum: best score and the ID that
// produced it. Ties keep the earlier candidate.
module oflow_score_board_min_reg
  import oflow_score_board_pkg::*;
(
  input  logic               clk,
  input  logic               reset_N,
  input  logic               clear,
  input  logic               valid,
  input  logic [SCORE_W-1:0] score,
  input  logic [ID_W-1:0]    id,
  output logic [SCORE_W-1:0] best_score,
  output logic [ID_W-1:0]    best_id
);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      best_score <= '1;
      best_id    <= '0;
    end else if (clear) begin
      best_score <= '1;
      best_id    <= '0;
    end else if (valid && (score < best_score)) begin
      best_score <= score;
      best_id    <= id;
    end
  end

endmodule

// File: rtl/oflow_score_board.sv
// Collects per-PE minimum scores for one set, then flushes
// one best-match record per PE into the result buffer.
module oflow_score_board
  import oflow_score_board_pkg::*;
(
  input logic               clk,
  input logic               reset_N,
  oflow_score_board_if.slave bus
);

  logic [1:0]         state;
  logic [PE_W-1:0]    pe_cnt;
  logic [SET_LEN-1:0] set_idx;

  logic [SCORE_W-1:0] best_score [NUM_PE];
  logic [ID_W-1:0]    best_id    [NUM_PE];

  logic               clear;
  logic               collect;
  logic [PE_W-1:0]    nxt_pe;
  logic [SET_LEN-1:0] last_idx;
  logic               last_set;
  logic [SCORE_W-1:0] cand0;
  logic [ID_W-1:0]    cand0_id;
  logic               take0;

  assign clear    = (state == ST_IDLE) && bus.start_score_calc;
  assign collect  = (state == ST_COLLECT);
  assign nxt_pe   = pe_cnt + PE_W'(1);
  assign last_idx = bus.num_of_sets - SET_LEN'(1);
  assign last_set = (set_idx == last_idx);

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    oflow_score_board_min_reg u_min (
      .clk        (clk),
      .reset_N    (reset_N),
      .clear      (clear),
      .valid      (collect & bus.score_valid[p]),
      .score      (bus.score[p*SCORE_W +: SCORE_W]),
      .id         (bus.score_id[p*ID_W +: ID_W]),
      .best_score (best_score[p]),
      .best_id    (best_id[p])
    );
  end

  // PE0 is written on the edge that ends COLLECT, so a
  // candidate arriving with done has to bypass its register.
  assign cand0    = bus.score[SCORE_W-1:0];
  assign cand0_id = bus.score_id[ID_W-1:0];
  assign take0    = collect && bus.score_valid[0] &&
                    (cand0 < best_score[0]);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state                <= ST_IDLE;
      pe_cnt               <= '0;
      set_idx              <= '0;
      bus.ready            <= 1'b1;
      bus.wr_en            <= 1'b0;
      bus.wr_addr          <= '0;
      bus.wr_data          <= '0;
      bus.done_score_board <= 1'b0;
      bus.overrun          <= 1'b0;
    end else begin
      bus.done_score_board <= 1'b0;

      if (bus.start_score_calc && (state != ST_IDLE))
        bus.overrun <= 1'b1;
      else if (bus.clr_status)
        bus.overrun <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (bus.start_score_calc) begin
            state     <= ST_COLLECT;
            set_idx   <= bus.counter_of_sets;
            bus.ready <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (bus.done_score_calc) begin
            state       <= ST_FLUSH;
            pe_cnt      <= '0;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= {set_idx, PE_W'(0)};
            bus.wr_data <= make_rec(
              take0 ? cand0    : best_score[0],
              take0 ? cand0_id : best_id[0]);
          end
        end
        ST_FLUSH: begin
          if (pe_cnt == PE_W'(NUM_PE-1)) begin
            state     <= ST_IDLE;
            bus.ready <= 1'b1;
            bus.wr_en <= 1'b0;
          end else begin
            pe_cnt      <= nxt_pe;
            bus.wr_addr <= {set_idx, nxt_pe};
            bus.wr_data <= make_rec(best_score[nxt_pe],
                                    best_id[nxt_pe]);
            bus.done_score_board <=
              (nxt_pe == PE_W'(NUM_PE-1)) && last_set;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus.ready <= 1'b1;
          bus.wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oflow_score_board.sv
// Directed bench for oflow_score_board: collect, flush,
// multi-set frames, overrun status and reset abort.
module tb_oflow_score_board;
  import oflow_score_board_pkg::*;

  localparam int W = 3 + ADDR_W + DATA_W;
  localparam logic [DATA_W-1:0] NONE = {1'b0, 7'h7F, 16'hFFFF};

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] exp_d [NUM_PE];

  oflow_score_board_if bus();

  oflow_score_board dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rec(
    input logic f,
    input logic [ID_W-1:0] id,
    input logic [SCORE_W-1:0] s
  );
    return {f, id, s};
  endfunction

  task automatic idle();
    bus.start_score_calc = 1'b0;
    bus.done_score_calc  = 1'b0;
    bus.clr_status       = 1'b0;
    bus.score_valid      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cand(
    input int pe,
    input logic [SCORE_W-1:0] s,
    input logic [ID_W-1:0] id
  );
    bus.score_valid[pe]             = 1'b1;
    bus.score[pe*SCORE_W +: SCORE_W] = s;
    bus.score_id[pe*ID_W +: ID_W]    = id;
  endtask

  task automatic start(input logic [SET_LEN-1:0] idx);
    bus.start_score_calc = 1'b1;
    bus.counter_of_sets  = idx;
  endtask

  task automatic test_reset();
    logic [W+1:0] got, want;
    idle();
    bus.counter_of_sets = '0;
    bus.num_of_sets     = 5'd1;
    bus.score           = '0;
    bus.score_id        = '0;
    tick();
    tick();
    got  = {bus.ready, bus.wr_en, bus.wr_addr, bus.wr_data,
            bus.done_score_board, bus.overrun};
    want = {1'b1, 1'b0, ADDR_W'(0), DATA_W'(0), 1'b0, 1'b0};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL reset_state: got %h want %h", got, want);
    end
    reset_N = 1'b1;
    tick();
  endtask

  task automatic test_single_set();
    logic [W-1:0] got, want;
    bus.num_of_sets = 5'd1;
    start(5'd0);
    tick();
    vectors++;
    if (bus.ready !== 1'b0) begin
      miscompares++;
      $display("FAIL single_ready_low: got %b want 0", bus.ready);
    end
    cand(0, 16'h0300, 7'd5);
    cand(1, 16'h0050, 7'd1);
    cand(2, 16'h0800, 7'd2);
    cand(4, 16'h0900, 7'd4);
    cand(7, 16'h0400, 7'h33);
    tick();
    cand(0, 16'h0100, 7'd9);
    cand(5, 16'h0801, 7'd5);
    cand(6, 16'h0000, 7'd6);
    tick();
    cand(0, 16'h0100, 7'd12);
    cand(7, 16'h0200, 7'h44);
    bus.done_score_calc = 1'b1;
    tick();
    exp_d[0] = rec(1'b1, 7'd9,  16'h0100);
    exp_d[1] = rec(1'b1, 7'd1,  16'h0050);
    exp_d[2] = rec(1'b1, 7'd2,  16'h0800);
    exp_d[3] = NONE;
    exp_d[4] = rec(1'b0, 7'h7F, 16'h0900);
    exp_d[5] = rec(1'b0, 7'h7F, 16'h0801);
    exp_d[6] = rec(1'b1, 7'd6,  16'h0000);
    exp_d[7] = rec(1'b1, 7'h44, 16'h0200);
    for (int k = 0; k < NUM_PE; k++) begin
      got  = {bus.wr_en, bus.wr_addr, bus.wr_data,
              bus.done_score_board, bus.ready};
      want = {1'b1, ADDR_W'(k), exp_d[k], k == NUM_PE-1, 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_write k=%0d: got %h want %h",
                 k, got, want);
      end
      tick();
    end
    vectors++;
    if ({bus.wr_en, bus.done_score_board, bus.ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL single_after: got %b want 001",
               {bus.wr_en, bus.done_score_board, bus.ready});
    end
  endtask

  task automatic test_same_cycle_done();
    logic [W-1:0] got, want;
    bus.num_of_sets = 5'd1;
    start(5'd0);
    tick();
    cand(0, 16'h0500, 7'd3);
    cand(1, 16'h0100, 7'd2);
    tick();
    cand(0, 16'h0020, 7'h11);
    cand(1, 16'h0100, 7'd3);
    bus.done_score_calc = 1'b1;
    tick();
    for (int k = 0; k < NUM_PE; k++) exp_d[k] = NONE;
    exp_d[0] = rec(1'b1, 7'h11, 16'h0020);
    exp_d[1] = rec(1'b1, 7'd2,  16'h0100);
    for (int k = 0; k < NUM_PE; k++) begin
      got  = {bus.wr_en, bus.wr_addr, bus.wr_data,
              bus.done_score_board, bus.ready};
      want = {1'b1, ADDR_W'(k), exp_d[k], k == NUM_PE-1, 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL same_cycle k=%0d: got %h want %h",
                 k, got, want);
      end
      tick();
    end
    vectors++;
    if ({bus.wr_en, bus.ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL same_cycle_after: got %b want 01",
               {bus.wr_en, bus.ready});
    end
  endtask

  task automatic test_multi_set();
    logic [W-1:0] got, want;
    bus.num_of_sets = 5'd3;
    for (int s = 0; s < 3; s++) begin
      tick();
      tick();
      start(SET_LEN'(s));
      tick();
      for (int p = 0; p < NUM_PE; p++)
        cand(p, SCORE_W'(s*16 + p), ID_W'(s*8 + p));
      tick();
      bus.done_score_calc = 1'b1;
      tick();
      for (int k = 0; k < NUM_PE; k++) begin
        got  = {bus.wr_en, bus.wr_addr, bus.wr_data,
                bus.done_score_board, bus.ready};
        want = {1'b1, ADDR_W'(s*8 + k),
                rec(1'b1, ID_W'(s*8 + k), SCORE_W'(s*16 + k)),
                (s == 2) && (k == NUM_PE-1), 1'b0};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL multi_write s=%0d k=%0d: got %h want %h",
                   s, k, got, want);
        end
        tick();
      end
      vectors++;
      if ({bus.wr_en, bus.done_score_board, bus.ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL multi_ready s=%0d: got %b want 001",
                 s, {bus.wr_en, bus.done_score_board, bus.ready});
      end
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] got, want;
    bus.num_of_sets = 5'd2;
    start(5'd0);
    tick();
    vectors++;
    if (bus.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_init: got %b want 0", bus.overrun);
    end
    cand(0, 16'h0010, 7'd1);
    start(5'd3);
    bus.clr_status = 1'b1;
    tick();
    vectors++;
    if (bus.overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_clr_same: got %b want 1", bus.overrun);
    end
    bus.done_score_calc = 1'b1;
    tick();
    for (int k = 0; k < NUM_PE; k++) exp_d[k] = NONE;
    exp_d[0] = rec(1'b1, 7'd1, 16'h0010);
    for (int k = 0; k < NUM_PE; k++) begin
      got  = {bus.wr_en, bus.wr_addr, bus.wr_data,
              bus.done_score_board, bus.ready};
      want = {1'b1, ADDR_W'(k), exp_d[k], 1'b0, 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL overrun_write k=%0d: got %h want %h",
                 k, got, want);
      end
      if (k == 1) start(5'd6);
      tick();
    end
    vectors++;
    if ({bus.wr_en, bus.ready, bus.overrun} !== 3'b011) begin
      miscompares++;
      $display("FAIL overrun_flush: got %b want 011",
               {bus.wr_en, bus.ready, bus.overrun});
    end
    bus.clr_status = 1'b1;
    tick();
    vectors++;
    if (bus.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %b want 0", bus.overrun);
    end
  endtask

  task automatic test_reset_flush();
    logic [W-1:0] got, want;
    bus.num_of_sets = 5'd1;
    start(5'd0);
    tick();
    cand(2, 16'h0040, 7'd7);
    bus.done_score_calc = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if ({bus.wr_en, bus.wr_addr} !== {1'b1, ADDR_W'(2)}) begin
      miscompares++;
      $display("FAIL rst_third_flush: got %b/%h want 1/02",
               bus.wr_en, bus.wr_addr);
    end
    reset_N = 1'b0;
    #1;
    got  = {bus.wr_en, bus.wr_addr, bus.wr_data,
            bus.done_score_board, bus.ready};
    want = {1'b0, ADDR_W'(0), DATA_W'(0), 1'b0, 1'b1};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL rst_abort: got %h want %h", got, want);
    end
    tick();
    tick();
    reset_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      vectors++;
      if ({bus.wr_en, bus.done_score_board, bus.ready} !== 3'b001) begin
        miscompares++;
        $display("FAIL rst_quiet c=%0d: got %b want 001",
                 c, {bus.wr_en, bus.done_score_board, bus.ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_same_cycle_done();
    test_multi_set();
    test_overrun();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oflow_score_board.md
Name: oflow_score_board

Overview:
- Downstream consumer of the per-frame registration score-calc sequencer.
- For each set it is told to process, it collects candidate match scores from NUM_PE parallel score-calc PEs and keeps a running minimum (best score + previous-frame object ID) per PE.
- When the set completes, it flushes one best-match record per PE into the registration result buffer, then signals frame completion after the last set.
- It sits between the score-calc PE array and the MEM buffer write port.

Parameters:
- NUM_PE, 8, number of parallel score-calc PEs per set (power of two).
- SCORE_W, 16, width of one candidate score (unsigned; lower is better).
- ID_W, 7, width of a previous-frame object ID.
- SET_LEN, 5, width of the set index and set count.
- SCORE_THRESH, 16'h0800, a best score above this means "no match".

Ports:
- clk  in  1  clock.
- reset_N  in  1  reset, asynchronous, active-low.
- start_score_calc  in  1  one-cycle pulse: a new set begins.
- counter_of_sets  in  SET_LEN  index of the set being started; sampled with start_score_calc.
- num_of_sets  in  SET_LEN  number of sets in the current frame.
- done_score_calc  in  1  one-cycle pulse: the PEs have finished the current set.
- score_valid  in  NUM_PE  per-PE candidate valid.
- score  in  NUM_PE*SCORE_W  per-PE candidate score, packed; PE0 in the LSBs.
- score_id  in  NUM_PE*ID_W  per-PE candidate previous-frame ID, packed.
- clr_status  in  1  clears the sticky overrun flag.
- ready  out  1  high in IDLE; the block can accept start_score_calc.
- wr_en  out  1  result buffer write strobe.
- wr_addr  out  SET_LEN+$clog2(NUM_PE)  result address = set_idx*NUM_PE + pe.
- wr_data  out  1+ID_W+SCORE_W  {found, id, score}.
- done_score_board  out  1  one-cycle pulse with the final write of the last set.
- overrun  out  1  sticky: start_score_calc arrived while not IDLE.

Behaviour:
- Reset values: state=IDLE; ready=1; wr_en=0; wr_addr=0; wr_data=0; done_score_board=0; overrun=0. Per-PE best_score resets to all-ones, best_id and set_idx to 0.
- Reset mid-operation aborts any collect or flush immediately; no partial writes complete.
- All outputs are registered.
- FSM states:
  - IDLE:
    - start_score_calc: load best_score[*]=all-ones and best_id[*]=0, latch set_idx=counter_of_sets, go to COLLECT.
    - score_valid and done_score_calc are ignored.
  - COLLECT:
    - Each cycle, for each PE with score_valid[p]=1 and score[p] < best_score[p] (strict less-than), update best_score[p] and best_id[p].
    - On a tie the earlier candidate is kept.
    - done_score_calc: candidates valid in the same cycle are still included; go to FLUSH with pe_cnt=0.
  - FLUSH:
    - For NUM_PE consecutive cycles, wr_en=1, wr_addr={set_idx, pe_cnt}, and wr_data is built from PE pe_cnt's best:
      - found = (best_score <= SCORE_THRESH).
      - When found=0: id field = all-ones, score field = best_score unchanged.
    - On pe_cnt==NUM_PE-1:
      - Return to IDLE.
      - If set_idx == num_of_sets-1 (SET_LEN-bit compare), pulse done_score_board in that same cycle.
- PE with no valid candidate in a set: best_score stays all-ones, so found=0, id=all-ones.
- Latency: done_score_calc at cycle T gives writes at T+1..T+NUM_PE; ready=1 again at T+NUM_PE+1.
- start_score_calc while in COLLECT or FLUSH: ignored, overrun set to 1. overrun clears on clr_status; clr_status and a new overrun in the same cycle leave overrun=1.
- done_score_calc while in FLUSH is ignored.
- num_of_sets=0 is illegal; done_score_board then fires only for set_idx=all-ones.
- Score compare is unsigned at SCORE_W; no saturation or arithmetic beyond compare.

Decomposition:
- Shared define/package: SCORE_W, ID_W, SCORE_THRESH, the wr_data field layout (found MSB, then id, then score), and the state enum {IDLE, COLLECT, FLUSH}.
- Sub-module oflow_score_board_min_reg, instanced NUM_PE times:
  - One PE's compare-and-hold.
  - Ports: clk, reset_N, clear, valid, score, id, best_score, best_id.
- The top keeps the FSM, pe_cnt, set_idx and the output mux.

Test Plan:
- Single set, num_of_sets=1, NUM_PE=8; PE0 gets scores 0x300 id 5, then 0x100 id 9, then 0x100 id 12 -> address 0 write {1,9,0x100}; done_score_board pulses together with the address-7 write.
- PE3 gets no valid candidates; PE4 best score is 0x0900 -> address 3 data {0,7'h7F,16'hFFFF}; address 4 data {0,7'h7F,16'h0900}.
- num_of_sets=3, sets 0..2 with start 2 cycles after ready -> 24 writes at addresses 0..23; done_score_board only on address 23; ready low for exactly 8 cycles after each done.
- Candidate valid in the same cycle as done_score_calc with a lower score -> that candidate is the one written.
- start_score_calc during FLUSH -> ignored, addresses unchanged, overrun=1; clr_status -> overrun=0.
- reset_N low on the third FLUSH cycle -> wr_en=0 immediately, state IDLE, no further writes, no done_score_board.
